// File: rtl/bit_counter_pkg.sv
// Shared constants for the bit-counter control FSM and its datapath.
package bit_counter_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultStepW = 4;

    // Binary-encoded FSM states.
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StTest  = 3'd2;
    localparam logic [2:0] StClear = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

endpackage

// File: rtl/bit_counter_control.sv
// Control FSM for the bit-counter datapath: load, shift/count until the operand drains,
// with a four-phase start/done handshake, abort and a drain-fault flag.
module bit_counter_control
    import bit_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned STEP_W = DefaultStepW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              A_0,
    input  logic              A_is_zero,
    output logic              ldA,
    output logic              resetA,
    output logic              shiftA,
    output logic              incr_counter,
    output logic              reset_counter,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [STEP_W-1:0] steps
);

    localparam logic [STEP_W-1:0] MaxSteps = STEP_W'(WIDTH);

    logic [2:0]        state_q, state_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              error_q, error_d;

    always_comb begin
        state_d       = state_q;
        steps_d       = steps_q;
        error_d       = error_q;
        ldA           = 1'b0;
        resetA        = 1'b0;
        shiftA        = 1'b0;
        incr_counter  = 1'b0;
        reset_counter = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    steps_d = '0;
                    error_d = 1'b0;
                end
            end
            StLoad: begin
                ldA           = 1'b1;
                reset_counter = 1'b1;
                busy          = 1'b1;
                state_d       = StTest;
            end
            StTest: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = StClear;
                end else if (A_is_zero) begin
                    state_d = StDone;
                    error_d = 1'b0;
                end else if (steps_q == MaxSteps) begin
                    // Operand failed to drain within WIDTH shifts.
                    state_d = StDone;
                    error_d = 1'b1;
                end else begin
                    shiftA       = 1'b1;
                    incr_counter = A_0;
                    steps_d      = steps_q + 1'b1;
                end
            end
            StClear: begin
                resetA        = 1'b1;
                reset_counter = 1'b1;
                busy          = 1'b1;
                state_d       = StIdle;
            end
            StDone: begin
                done = 1'b1;
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            steps_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            error_q <= error_d;
        end
    end

    assign steps = steps_q;
    assign error = error_q;

endmodule

// File: doc/bit_counter_control.md
Name: bit_counter_control

Overview:
- Control FSM for the bit-counter datapath: issues ldA/resetA/shiftA/incr_counter/reset_counter and consumes datapath status A_0/A_is_zero.
- Datapath semantics:
  - Each shift moves the next bit under test into A_0.
  - A_is_zero flags an all-zero operand register.
- Host side is a four-phase start/done handshake, plus abort and a fault flag when the operand never drains to zero.
- Sits between the host/sequencer and one datapath instance; the datapath holds the operand and the ones count.

Parameters:
- WIDTH, 8, operand width = maximum legal number of shifts per operation.
- STEP_W, 4, width of step counter/steps output; must hold WIDTH (STEP_W >= clog2(WIDTH+1)).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  host request, level; four-phase with done.
- abort  in  1  host cancel; honoured only in TEST.
- A_0  in  1  datapath: current bit under test (registered value).
- A_is_zero  in  1  datapath: operand register == 0 (registered value).
- ldA  out  1  load operand.
- resetA  out  1  clear operand.
- shiftA  out  1  shift operand one position.
- incr_counter  out  1  increment ones counter.
- reset_counter  out  1  clear ones counter.
- busy  out  1  high in LOAD, TEST, CLEAR.
- done  out  1  high in DONE.
- error  out  1  fault: WIDTH shifts done and A_is_zero still 0; valid while done=1.
- steps  out  STEP_W  number of shifts issued in the current/last operation.

Behaviour:
- Reset (sync, clk edge with reset=1) overrides everything:
  - State to IDLE.
  - steps=0, error=0.
  - All control outputs, busy and done read 0.
  - Applies mid-operation too; the datapath is not cleared by reset. The next LOAD does that.
- State register updates on posedge clk. Control outputs are decoded from the current state plus status inputs in the same cycle. Datapath status is valid because the datapath updates on the same edge.
- IDLE:
  - All controls 0; busy=0; done=0.
  - start=1 -> LOAD; clear steps and error on that edge.
- LOAD (1 cycle):
  - ldA=1, reset_counter=1.
  - -> TEST unconditionally; abort ignored.
- TEST, priority order:
  1. abort=1 -> CLEAR; no shift or incr this cycle.
  2. A_is_zero=1 -> DONE, error=0; no shift or incr.
  3. steps==WIDTH -> DONE, error=1; no shift or incr.
  4. Otherwise: shiftA=1, incr_counter=A_0 (same cycle), steps<=steps+1; stay in TEST.
  - incr_counter is never asserted without shiftA.
- CLEAR (1 cycle):
  - resetA=1, reset_counter=1.
  - -> IDLE; done is never asserted for an aborted operation.
  - steps holds its value.
- DONE:
  - done=1; steps and error hold.
  - Stay while start=1; start=0 -> IDLE.
  - A new operation requires start to drop and then rise again.
- start while busy is ignored. Abort outside TEST is ignored.
- Latency: start sampled at edge e0, giving LOAD in cycle e0..e1. For k shifts, done rises after edge e(k+2). A zero operand gives done after e2.
- steps never wraps: max WIDTH, enforced by the TEST guard.
- Reset and start high together: reset wins; IDLE next cycle; start is seen on the following edge.

Decomposition:
- Package bit_counter_pkg:
  - State enum IDLE/LOAD/TEST/CLEAR/DONE (binary, 3 bits).
  - Default WIDTH and STEP_W constants, shared with the datapath.
- Single module; no sub-module. The step counter is inline.
- The bench pairs it with a behavioural datapath model: right-shift, A_0 = LSB, and its own ones counter.

Test Plan:
- A=8'hB1, start held -> 8 shiftA pulses, 4 incr_counter pulses (cycles where A_0=1), model count=4, steps=8, error=0. done rises 10 cycles after the start edge and holds until start=0, then IDLE.
- A=8'h00 -> LOAD then DONE: zero shiftA/incr_counter, steps=0, count=0, done 2 cycles after start.
- A=8'h01 -> 1 shift, 1 incr, steps=1, done after 3 cycles. Re-pulse start without dropping it: no second operation.
- A=8'hFF, abort=1 on the 3rd TEST cycle -> exactly 2 shifts, then one CLEAR cycle with resetA=reset_counter=1, then IDLE. done never asserted; steps=2.
- Faulty model with A_is_zero stuck 0, A=8'h80 -> exactly WIDTH=8 shifts, then done=1, error=1, steps=8. Next operation clears error.
- reset=1 mid-TEST (after 3 shifts) -> next cycle IDLE, all outputs 0, steps=0. A following start runs a full operation correctly.
